// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: compare-mode encodings and 2-bit counter constants.
package branch_pkg;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'd0,
      BR_BNE  = 3'd1,
      BR_BLEZ = 3'd2,
      BR_BGTZ = 3'd3,
      BR_BLTZ = 3'd4,
      BR_BGEZ = 3'd5
   } br_op_e;

   localparam int unsigned        CTR_W     = 2;
   localparam logic [CTR_W-1:0]   CTR_RESET = 2'd1;
   localparam logic [CTR_W-1:0]   CTR_ALLOC = 2'd2;
   localparam logic [CTR_W-1:0]   CTR_MAX   = 2'd3;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup, execute-resolve and redirect signals of the branch unit.
interface branch_predict_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic [ADDR_W-1:0] fetch_pc;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_target;
   logic              resolve_valid;
   logic [2:0]        resolve_op;
   logic [31:0]       rs_val;
   logic [31:0]       rt_val;
   logic [ADDR_W-1:0] resolve_pc;
   logic [ADDR_W-1:0] branch_pc;
   logic [ADDR_W-1:0] pc_add_4;
   logic              ex_pred_taken;
   logic [ADDR_W-1:0] ex_pred_target;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   modport master (
      output fetch_pc, resolve_valid, resolve_op, rs_val, rt_val, resolve_pc,
             branch_pc, pc_add_4, ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, redirect_valid, redirect_pc
   );

   modport slave (
      input  fetch_pc, resolve_valid, resolve_op, rs_val, rt_val, resolve_pc,
             branch_pc, pc_add_4, ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: compare mode and operands to taken/not-taken.
module branch_cond_eval
   import branch_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_rs,
   input  logic [31:0] i_rt,
   output logic        o_taken
);
   logic w_rs_neg;
   logic w_rs_zero;

   assign w_rs_neg  = i_rs[31];
   assign w_rs_zero = (i_rs == 32'd0);

   always_comb begin
      o_taken = 1'b0;
      case (i_op)
         BR_BEQ:  o_taken = (i_rs == i_rt);
         BR_BNE:  o_taken = (i_rs != i_rt);
         BR_BLEZ: o_taken = w_rs_neg || w_rs_zero;
         BR_BGTZ: o_taken = !w_rs_neg && !w_rs_zero;
         BR_BLTZ: o_taken = w_rs_neg;
         BR_BGEZ: o_taken = !w_rs_neg;
         default: o_taken = 1'b0;
      endcase
   end
endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus direct-mapped BTB with 2-bit counters and registered redirect.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   branch_predict_unit_if.slave  bp_if
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]           o_stat_branches,
   output logic [31:0]           o_stat_mispredicts
`endif
);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

   logic              r_valid  [DEPTH];
   logic [TAG_W-1:0]  r_tag    [DEPTH];
   logic [ADDR_W-1:0] r_target [DEPTH];
   logic [CTR_W-1:0]  r_ctr    [DEPTH];
   logic              r_redirect_valid;
   logic [ADDR_W-1:0] r_redirect_pc;

   logic [IDX_W-1:0]  w_fidx;
   logic [TAG_W-1:0]  w_ftag;
   logic              w_fhit;
   logic [IDX_W-1:0]  w_ridx;
   logic [TAG_W-1:0]  w_rtag;
   logic              w_rhit;
   logic              w_taken;
   logic              w_accept;
   logic              w_mispredict;
   logic              w_unused;

   assign w_unused = ^{bp_if.fetch_pc[1:0], bp_if.resolve_pc[1:0]};

   assign w_fidx = bp_if.fetch_pc[IDX_W+1:2];
   assign w_ftag = bp_if.fetch_pc[ADDR_W-1:IDX_W+2];
   assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);

   assign bp_if.pred_taken  = w_fhit && r_ctr[w_fidx][CTR_W-1];
   assign bp_if.pred_target = bp_if.pred_taken ? r_target[w_fidx] : '0;

   branch_cond_eval u_cond (
      .i_op    (bp_if.resolve_op),
      .i_rs    (bp_if.rs_val),
      .i_rt    (bp_if.rt_val),
      .o_taken (w_taken)
   );

   assign w_ridx = bp_if.resolve_pc[IDX_W+1:2];
   assign w_rtag = bp_if.resolve_pc[ADDR_W-1:IDX_W+2];
   assign w_rhit = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);

   // A resolve during the redirect cycle is on the flushed wrong path.
   assign w_accept     = bp_if.resolve_valid && !r_redirect_valid;
   assign w_mispredict = (w_taken != bp_if.ex_pred_taken) ||
                         (w_taken && bp_if.ex_pred_taken &&
                          (bp_if.ex_pred_target != bp_if.branch_pc));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= CTR_RESET;
         end
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= w_accept && w_mispredict;
         if (w_accept && w_mispredict) begin
            r_redirect_pc <= w_taken ? bp_if.branch_pc : bp_if.pc_add_4;
         end
         if (w_accept) begin
            if (w_rhit) begin
               if (w_taken) begin
                  r_target[w_ridx] <= bp_if.branch_pc;
                  if (r_ctr[w_ridx] != CTR_MAX) begin
                     r_ctr[w_ridx] <= r_ctr[w_ridx] + CTR_W'(1);
                  end
               end else if (r_ctr[w_ridx] != '0) begin
                  r_ctr[w_ridx] <= r_ctr[w_ridx] - CTR_W'(1);
               end
            end else if (w_taken) begin
               r_valid[w_ridx]  <= 1'b1;
               r_tag[w_ridx]    <= w_rtag;
               r_target[w_ridx] <= bp_if.branch_pc;
               r_ctr[w_ridx]    <= CTR_ALLOC;
            end
         end
      end
   end

   assign bp_if.redirect_valid = r_redirect_valid;
   assign bp_if.redirect_pc    = r_redirect_pc;

`ifdef BRANCH_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stat_branches    <= '0;
         r_stat_mispredicts <= '0;
      end else begin
         if (w_accept && (r_stat_branches != '1)) begin
            r_stat_branches <= r_stat_branches + 32'd1;
         end
         if (w_accept && w_mispredict && (r_stat_mispredicts != '1)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign o_stat_branches    = r_stat_branches;
   assign o_stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a table-level reference model checked every cycle.
module tb_branch_predict_unit;
   logic clk;
   logic reset;
   int   n_vec = 0;
   int   n_mis = 0;
   bit   chk_en = 1'b0;

   branch_predict_unit_if #(.ADDR_W(32)) bp_if ();

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_br;
   logic [31:0] stat_mis;
`endif

   branch_predict_unit #(.ADDR_W(32), .DEPTH(16)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bp_if   (bp_if)
`ifdef BRANCH_STATS_EN
      ,
      .o_stat_branches    (stat_br),
      .o_stat_mispredicts (stat_mis)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference table: one record per slot, counters as plain integers 0..3.
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   bit          m_rv;
   logic [31:0] m_rpc;
   int          m_nbr;
   int          m_nmis;

   function automatic bit m_taken(input logic [2:0] op, input logic [31:0] rs,
                                  input logic [31:0] rt);
      int s;
      s = int'(rs);
      case (op)
         3'd0:    return rs == rt;
         3'd1:    return rs != rt;
         3'd2:    return s <= 0;
         3'd3:    return s > 0;
         3'd4:    return s < 0;
         3'd5:    return s >= 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            for (int i = 0; i < 16; i++) begin
               m_valid[i] = 1'b0;
               m_ctr[i]   = 1;
            end
            m_rv   = 1'b0;
            m_rpc  = 32'd0;
            m_nbr  = 0;
            m_nmis = 0;
         end else begin
            bit nrv;
            nrv = 1'b0;
            if (bp_if.resolve_valid && !m_rv) begin
               bit tk, mis, hit;
               int i;
               tk  = m_taken(bp_if.resolve_op, bp_if.rs_val, bp_if.rt_val);
               mis = (tk != bp_if.ex_pred_taken) ||
                     (tk && bp_if.ex_pred_taken && bp_if.ex_pred_target != bp_if.branch_pc);
               i   = int'((bp_if.resolve_pc >> 2) % 16);
               hit = m_valid[i] && (m_tag[i] == (bp_if.resolve_pc >> 6));
               if (hit && tk) begin
                  m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                  m_tgt[i] = bp_if.branch_pc;
               end else if (hit) begin
                  m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
               end else if (tk) begin
                  m_valid[i] = 1'b1;
                  m_tag[i]   = bp_if.resolve_pc >> 6;
                  m_tgt[i]   = bp_if.branch_pc;
                  m_ctr[i]   = 2;
               end
               m_nbr++;
               if (mis) begin
                  nrv   = 1'b1;
                  m_rpc = tk ? bp_if.branch_pc : bp_if.pc_add_4;
                  m_nmis++;
               end
            end
            m_rv = nrv;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            int  i;
            bit  ep;
            i  = int'((bp_if.fetch_pc >> 2) % 16);
            ep = m_valid[i] && (m_tag[i] == (bp_if.fetch_pc >> 6)) && (m_ctr[i] >= 2);
            chk("model pred_taken", 32'(bp_if.pred_taken), 32'(ep));
            chk("model pred_target", bp_if.pred_target, ep ? m_tgt[i] : 32'd0);
            chk("model redirect_valid", 32'(bp_if.redirect_valid), 32'(m_rv));
            if (m_rv) chk("model redirect_pc", bp_if.redirect_pc, m_rpc);
         end
      end
   end

   logic        got_rv;
   logic [31:0] got_rpc;

   task automatic do_resolve(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] rpc, input logic [31:0] bpc, input logic ept,
                             input logic [31:0] eptg);
      bp_if.resolve_valid  = 1'b1;
      bp_if.resolve_op     = op;
      bp_if.rs_val         = rs;
      bp_if.rt_val         = rt;
      bp_if.resolve_pc     = rpc;
      bp_if.branch_pc      = bpc;
      bp_if.pc_add_4       = rpc + 32'd4;
      bp_if.ex_pred_taken  = ept;
      bp_if.ex_pred_target = eptg;
      @(posedge clk); #1;
      bp_if.resolve_valid = 1'b0;
      @(negedge clk);
      got_rv  = bp_if.redirect_valid;
      got_rpc = bp_if.redirect_pc;
      @(posedge clk); #1;
   endtask

   task automatic fetch_chk(input string nm, input logic [31:0] pc, input logic et,
                            input logic [31:0] etg);
      bp_if.fetch_pc = pc;
      #1;
      chk({nm, " taken"}, 32'(bp_if.pred_taken), 32'(et));
      chk({nm, " target"}, bp_if.pred_target, etg);
   endtask

   initial begin
      reset = 1'b1;
      bp_if.fetch_pc = 32'h100;
      bp_if.resolve_valid = 1'b0;
      bp_if.resolve_op = 3'd0;
      bp_if.rs_val = '0;
      bp_if.rt_val = '0;
      bp_if.resolve_pc = '0;
      bp_if.branch_pc = '0;
      bp_if.pc_add_4 = '0;
      bp_if.ex_pred_taken = 1'b0;
      bp_if.ex_pred_target = '0;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;

      fetch_chk("reset 0x100", 32'h100, 1'b0, 32'h0);
      fetch_chk("reset 0x3fc", 32'h3fc, 1'b0, 32'h0);
      chk("reset redirect_valid", 32'(bp_if.redirect_valid), 32'h0);
      chk("reset redirect_pc", bp_if.redirect_pc, 32'h0);

      // Cold taken BEQ allocates with counter 2.
      do_resolve(3'd0, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0, 32'h0);
      chk("cold redirect_valid", 32'(got_rv), 32'h1);
      chk("cold redirect_pc", got_rpc, 32'h140);
      fetch_chk("cold lookup", 32'h100, 1'b1, 32'h140);

      for (int k = 0; k < 3; k++) begin
         do_resolve(3'd0, 32'd9, 32'd9, 32'h100, 32'h140, 1'b1, 32'h140);
         chk("train no redirect", 32'(got_rv), 32'h0);
      end
      do_resolve(3'd1, 32'd7, 32'd7, 32'h100, 32'h140, 1'b1, 32'h140);
      chk("untrain1 redirect_pc", got_rpc, 32'h104);
      fetch_chk("ctr2 lookup", 32'h100, 1'b1, 32'h140);
      do_resolve(3'd1, 32'd7, 32'd7, 32'h100, 32'h140, 1'b1, 32'h140);
      chk("untrain2 redirect_valid", 32'(got_rv), 32'h1);
      fetch_chk("ctr1 lookup", 32'h100, 1'b0, 32'h0);

      do_resolve(3'd4, 32'hffff_ffff, 32'd0, 32'h204, 32'h300, 1'b0, 32'h0);
      chk("bltz neg redirect_pc", got_rpc, 32'h300);
      do_resolve(3'd5, 32'd0, 32'd0, 32'h208, 32'h400, 1'b0, 32'h0);
      chk("bgez zero redirect_pc", got_rpc, 32'h400);
      do_resolve(3'd3, 32'd0, 32'd0, 32'h20c, 32'h500, 1'b0, 32'h0);
      chk("bgtz zero redirect_valid", 32'(got_rv), 32'h0);
      fetch_chk("bgtz no alloc", 32'h20c, 1'b0, 32'h0);

      // Wrong-path resolve arriving in the redirect cycle.
      bp_if.resolve_valid = 1'b1;
      bp_if.resolve_op = 3'd0;
      bp_if.rs_val = 32'd1;
      bp_if.rt_val = 32'd1;
      bp_if.resolve_pc = 32'h214;
      bp_if.branch_pc = 32'h500;
      bp_if.pc_add_4 = 32'h218;
      bp_if.ex_pred_taken = 1'b0;
      @(posedge clk); #1;
      bp_if.resolve_pc = 32'h218;
      bp_if.branch_pc = 32'h600;
      bp_if.pc_add_4 = 32'h21c;
      @(negedge clk);
      chk("wrongpath first redirect", bp_if.redirect_pc, 32'h500);
      @(posedge clk); #1;
      bp_if.resolve_valid = 1'b0;
      @(negedge clk);
      chk("wrongpath no second redirect", 32'(bp_if.redirect_valid), 32'h0);
      @(posedge clk); #1;
      fetch_chk("wrongpath no write", 32'h218, 1'b0, 32'h0);
      fetch_chk("wrongpath first kept", 32'h214, 1'b1, 32'h500);

      // 0x140 shares slot 0 with 0x100 under a different tag.
      do_resolve(3'd0, 32'd3, 32'd3, 32'h140, 32'h1000, 1'b0, 32'h0);
      chk("conflict redirect_pc", got_rpc, 32'h1000);
      fetch_chk("evicted 0x100", 32'h100, 1'b0, 32'h0);
      fetch_chk("new 0x140", 32'h140, 1'b1, 32'h1000);

      do_resolve(3'd0, 32'd3, 32'd3, 32'h140, 32'h180, 1'b1, 32'h1000);
      chk("target mismatch redirect_pc", got_rpc, 32'h180);
      fetch_chk("target retrained", 32'h140, 1'b1, 32'h180);

      do_resolve(3'd6, 32'd3, 32'd3, 32'h140, 32'h180, 1'b1, 32'h180);
      chk("op6 redirect_pc", got_rpc, 32'h144);

      // Reset coinciding with a mispredicting resolve.
      bp_if.resolve_valid = 1'b1;
      bp_if.resolve_op = 3'd0;
      bp_if.resolve_pc = 32'h21c;
      bp_if.branch_pc = 32'h700;
      bp_if.pc_add_4 = 32'h220;
      bp_if.ex_pred_taken = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      bp_if.resolve_valid = 1'b0;
      @(negedge clk);
      chk("reset drops redirect", 32'(bp_if.redirect_valid), 32'h0);
      fetch_chk("reset clears table", 32'h140, 1'b0, 32'h0);
      fetch_chk("reset wins update", 32'h21c, 1'b0, 32'h0);

`ifdef BRANCH_STATS_EN
      do_resolve(3'd0, 32'd1, 32'd2, 32'h300, 32'h800, 1'b1, 32'h800);
      chk("stat branches", stat_br, 32'(m_nbr));
      chk("stat mispredicts", stat_mis, 32'(m_nmis));
      chk("stat literal", stat_br, 32'd1);
`endif

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the MIPS pipeline. It generalises taken/not-taken next-PC selection to six compare modes. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, used for fetch-stage prediction. It emits a registered redirect (flush + corrected PC) when the execute-stage outcome disagrees with the prediction carried down the pipe.

## Interface
- ADDR_W, 32: PC/target width.
- DEPTH, 16: BTB entries; power of two, ≥2. IDX_W = log2(DEPTH).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_pc  in  ADDR_W  PC being fetched.
- pred_taken  out  1  fetch prediction (combinational).
- pred_target  out  ADDR_W  predicted target; 0 when pred_taken=0.
- resolve_valid  in  1  execute-stage branch present this cycle.
- resolve_op  in  3  compare mode: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ; 6–7 never taken.
- rs_val, rt_val  in  32  operands, signed for BLEZ/BGTZ/BLTZ/BGEZ.
- resolve_pc  in  ADDR_W  PC of the resolving branch.
- branch_pc  in  ADDR_W  computed branch target.
- pc_add_4  in  ADDR_W  fall-through PC.
- ex_pred_taken  in  1  prediction made for this branch at fetch.
- ex_pred_target  in  ADDR_W  predicted target made at fetch.
- redirect_valid  out  1  flush younger stages; load redirect_pc.
- redirect_pc  out  ADDR_W  corrected next PC.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. Each entry holds valid, tag, target and a 2-bit counter.
- **Lookup:**
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = entry target when pred_taken, else 0.
- **Actual outcome** (taken), by mode:
  - BEQ: rs==rt. BNE: rs!=rt.
  - BLEZ: rs≤0. BGTZ: rs>0.
  - BLTZ: rs<0. BGEZ: rs≥0.
- **Mispredict** = taken != ex_pred_taken, OR (taken && ex_pred_taken && ex_pred_target != branch_pc).
- **Table update** on an accepted resolve:
  - Hit: counter saturating +1 if taken (max 3), −1 if not (min 0); target ← branch_pc if taken.
  - Miss and taken: allocate (overwrite) with valid=1, tag, target=branch_pc, ctr=2.
  - Miss and not taken: no write.
- **Accepted resolve** = resolve_valid && !redirect_valid. A resolve arriving while redirect_valid=1 is wrong-path: no update, no redirect.
- **Redirect:** on an accepted mispredict, next cycle redirect_valid=1 and redirect_pc = taken ? branch_pc : pc_add_4. Otherwise redirect_valid=0 next cycle.

## Timing
- Reset values:
  - all valid=0, all counters=1 (weakly not-taken);
  - redirect_valid=0, redirect_pc=0;
  - statistics counters 0.
- Lookup is combinational, zero latency.
- Table writes take effect at the edge ending the resolve cycle.
- Same-cycle lookup and update of one index: lookup returns the pre-update contents; no bypass.
- Redirect latency: exactly 1 cycle after the resolve cycle. redirect_valid is high for one cycle per mispredict and never asserts on consecutive cycles.
- Reset asserted in the resolve cycle or the redirect cycle: the pending redirect is dropped and table state is cleared; reset wins over update.
- Ops 6–7 are never taken. If ex_pred_taken=1, they cause a redirect to pc_add_4.

## Configuration
- BRANCH_STATS_EN, defined:
  - Adds outputs stat_branches (32) and stat_mispredicts (32).
  - stat_branches counts accepted resolves; stat_mispredicts counts accepted mispredicts.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- BRANCH_STATS_EN undefined: the ports and counters do not exist.

## Structure
- Shared package branch_pkg holds:
  - op encodings BR_BEQ..BR_BGEZ;
  - counter constants CTR_W=2, CTR_RESET=1, CTR_ALLOC=2, CTR_MAX=3.
- Sub-module branch_cond_eval: purely combinational op/rs/rt → taken. All state lives in the top.

## Test plan
- **Reset:** after reset, any fetch_pc gives pred_taken=0 and pred_target=0; redirect_valid=0.
- **Cold taken branch:** BEQ at 0x100, rs=rt=5, ex_pred_taken=0, branch_pc=0x140 → next cycle redirect_valid=1, redirect_pc=0x140. Then fetch_pc=0x100 gives pred_taken=1, pred_target=0x140.
- **Counter saturation and training:**
  - Resolve 0x100 taken three more times → counter 3.
  - One not-taken BNE (rs=rt), ex_pred_taken=1 → redirect to pc_add_4=0x104; prediction still taken (ctr=2).
  - A second not-taken → ctr=1, pred_taken=0.
- **Signed modes:**
  - BLTZ with rs=0xFFFFFFFF → taken.
  - BGEZ with rs=0 → taken.
  - BGTZ with rs=0 → not taken.
- **Wrong-path suppression and conflict:**
  - Mispredict at cycle N, then resolve_valid at N+1 (redirect high) → no table change, no second redirect.
  - DEPTH=16: a taken branch at 0x140 evicts the 0x100 entry (same index); 0x100 lookup then misses.
- **Target mismatch:** hit entry predicts 0x140 but branch_pc=0x180 and taken → redirect_pc=0x180; entry target becomes 0x180.
